// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage for the 8-bit dual-74181 ALU.
// The block takes requests over a valid/ready handshake and registers them onto the ALU inputs.
// It then waits SETTLE_CYCLES edges and captures the ALU result and flags.
// A stored carry flag lets multi-byte arithmetic be chained one byte per request.
// Optional feature macro: ZF_CHAIN_EN. When it is defined, the zero flag is ANDed across
// ops that were issued with req_use_cf=1, which gives a multi-byte zero/equality result.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [3:0] req_sel,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  input  logic       req_use_cf,
  output logic       alu_mode,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_f,
  input  logic       alu_cout,
  input  logic       alu_zf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_f,
  output logic       rsp_cf,
  output logic       rsp_zf,
  output logic       cf,
  output logic       zf,
  output logic       busy
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
      $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [3:0] settleCnt;
  logic       accept;
  logic       capture;
  logic       zfCapture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake decode. In RESP, req_ready follows rsp_ready so a
  // response handshake and a new accept can share one edge.
  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) begin
          stateNext = DRIVE;
        end
      end
      DRIVE: begin
        if (settleCnt == '0) begin
          capture   = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        req_ready = rsp_ready;
        accept    = req_valid & rsp_ready;
        if (rsp_ready) begin
          stateNext = req_valid ? DRIVE : IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Settle counter: it loads at accept and counts down while DRIVE waits for the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt <= '0;
    end else if (accept) begin
      settleCnt <= SETTLE_LOAD;
    end else if (state == DRIVE && settleCnt != '0) begin
      settleCnt <= settleCnt - 4'd1;
    end
  end

  // ALU input registers: they load only at accept and hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_mode <= 1'b0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
    end else if (accept) begin
      alu_mode <= req_mode;
      alu_sel  <= req_sel;
      alu_a    <= req_a;
      alu_b    <= req_b;
      alu_cin  <= req_use_cf ? cf : req_cin;
    end
  end

`ifdef ZF_CHAIN_EN
  logic opUseCf;

  // Remember whether the in-flight op chains on the stored flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opUseCf <= 1'b0;
    end else if (accept) begin
      opUseCf <= req_use_cf;
    end
  end

  assign zfCapture = opUseCf ? (zf & alu_zf) : alu_zf;
`else
  assign zfCapture = alu_zf;
`endif

  // Response and persistent flag registers: they change only at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_f  <= '0;
      rsp_cf <= 1'b0;
      rsp_zf <= 1'b0;
      cf     <= 1'b0;
      zf     <= 1'b0;
    end else if (capture) begin
      rsp_f  <= alu_f;
      rsp_cf <= alu_cout;
      rsp_zf <= zfCapture;
      cf     <= alu_cout;
      zf     <= zfCapture;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// Two instances are used: dut1 (SETTLE_CYCLES=1) is the main target and dut3
// (SETTLE_CYCLES=3) covers the longer latency. Each one drives a bench adder model
// that stands in for the ALU.
module tb_alu_op_sequencer;

  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       reqMode, reqCin, reqUseCf;
  logic [3:0] reqSel;
  logic [7:0] reqA, reqB;

  logic       v1, r1, aluMode1, aluCin1, aluCout1, aluZf1, rspValid1, rspReady1;
  logic       rspCf1, rspZf1, cf1, zf1, busy1;
  logic [3:0] aluSel1;
  logic [7:0] aluA1, aluB1, aluF1, rspF1;

  logic       v3, r3, aluMode3, aluCin3, aluCout3, aluZf3, rspValid3, rspReady3;
  logic       rspCf3, rspZf3, cf3, zf3, busy3;
  logic [3:0] aluSel3;
  logic [7:0] aluA3, aluB3, aluF3, rspF3;

  assign {aluCout1, aluF1} = 9'(aluA1) + 9'(aluB1) + 9'(aluCin1);
  assign aluZf1 = (aluF1 == 8'h00);
  assign {aluCout3, aluF3} = 9'(aluA3) + 9'(aluB3) + 9'(aluCin3);
  assign aluZf3 = (aluF3 == 8'h00);

  alu_op_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1),
    .req_mode(reqMode), .req_sel(reqSel), .req_a(reqA), .req_b(reqB),
    .req_cin(reqCin), .req_use_cf(reqUseCf),
    .alu_mode(aluMode1), .alu_sel(aluSel1), .alu_a(aluA1), .alu_b(aluB1), .alu_cin(aluCin1),
    .alu_f(aluF1), .alu_cout(aluCout1), .alu_zf(aluZf1),
    .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_f(rspF1), .rsp_cf(rspCf1),
    .rsp_zf(rspZf1), .cf(cf1), .zf(zf1), .busy(busy1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(S3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(r3),
    .req_mode(reqMode), .req_sel(reqSel), .req_a(reqA), .req_b(reqB),
    .req_cin(reqCin), .req_use_cf(reqUseCf),
    .alu_mode(aluMode3), .alu_sel(aluSel3), .alu_a(aluA3), .alu_b(aluB3), .alu_cin(aluCin3),
    .alu_f(aluF3), .alu_cout(aluCout3), .alu_zf(aluZf3),
    .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_f(rspF3), .rsp_cf(rspCf3),
    .rsp_zf(rspZf3), .cf(cf3), .zf(zf3), .busy(busy3)
  );

  int passed = 0;
  int total  = 0;

  // Reference state for dut1: the stored flags and the last expected response
  bit       mCf = 1'b0;
  bit       mZf = 1'b0;
  bit [7:0] mF  = 8'h00;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       useCf;
    logic [7:0] expF;
    logic       expCf;
    logic       expZf;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Present a request to dut1, wait (bounded) for acceptance, and check the registered ALU inputs
  task automatic accept1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic useCf, input logic mode, input logic [3:0] sel,
                         output logic expCin);
    int n;
    reqA = a; reqB = b; reqCin = cin; reqUseCf = useCf; reqMode = mode; reqSel = sel;
    v1 = 1'b1;
    n = 0;
    while (!r1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    expCin = useCf ? mCf : cin;
    if (!r1) begin
      total++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles", n);
      v1 = 1'b0;
    end else begin
      @(posedge clk); #1;
      v1 = 1'b0;
      check("alu_a", aluA1, a);
      check("alu_b", aluB1, b);
      check("alu_cin", aluCin1, expCin);
      check("alu_mode", aluMode1, mode);
      check("alu_sel", aluSel1, sel);
      check("drive_req_ready", r1, 0);
      check("drive_busy", busy1, 1);
    end
  endtask

  // Wait (bounded) for the dut1 response, check the latency and the captured values, then update the model
  task automatic waitRsp1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic useCf);
    int lat;
    logic [8:0] s;
    logic fz, ez;
    lat = 0;
    while (!rspValid1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency1", lat, S1);
    s  = 9'(a) + 9'(b) + 9'(cin);
    fz = (s[7:0] == 8'h00);
`ifdef ZF_CHAIN_EN
    ez = useCf ? (mZf & fz) : fz;
`else
    ez = fz;
`endif
    check("rsp_f", rspF1, s[7:0]);
    check("rsp_cf", rspCf1, s[8]);
    check("rsp_zf", rspZf1, ez);
    check("cf", cf1, s[8]);
    check("zf", zf1, ez);
    mCf = s[8]; mZf = ez; mF = s[7:0];
  endtask

  task automatic release1();
    rspReady1 = 1'b1;
    @(posedge clk); #1;
    rspReady1 = 1'b0;
    check("release_rsp_valid", rspValid1, 0);
    check("release_busy", busy1, 0);
    check("release_req_ready", r1, 1);
  endtask

  task automatic runOp1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic useCf, input logic mode, input logic [3:0] sel);
    logic ec;
    accept1(a, b, cin, useCf, mode, sel, ec);
    waitRsp1(a, b, ec, useCf);
    release1();
  endtask

  initial begin
    logic ec;
    logic [7:0] ra, rb;
    logic rc, ru;

    tbl[0] = '{a: 8'h3C, b: 8'h05, cin: 1'b0, useCf: 1'b0, expF: 8'h41, expCf: 1'b0, expZf: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, useCf: 1'b0, expF: 8'h00, expCf: 1'b1, expZf: 1'b1};
    tbl[2] = '{a: 8'h01, b: 8'h00, cin: 1'b0, useCf: 1'b1, expF: 8'h02, expCf: 1'b0, expZf: 1'b0};
    tbl[3] = '{a: 8'h10, b: 8'h10, cin: 1'b1, useCf: 1'b1, expF: 8'h20, expCf: 1'b0, expZf: 1'b0};

    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; rspReady1 = 1'b0; rspReady3 = 1'b0;
    reqMode = 1'b0; reqSel = '0; reqA = '0; reqB = '0; reqCin = 1'b0; reqUseCf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_req_ready", r1, 1);
    check("reset_rsp_valid", rspValid1, 0);
    check("reset_busy", busy1, 0);
    check("reset_cf_zf", {cf1, zf1}, 0);
    check("reset_alu", {aluMode1, aluSel1, aluA1, aluB1, aluCin1}, 0);
    check("reset_rsp", {rspF1, rspCf1, rspZf1}, 0);

    // Table-driven ops on dut1. The chain through stored cf starts at entry 1.
    for (int i = 0; i < 4; i++) begin
      accept1(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].useCf, 1'b0, 4'h9, ec);
      waitRsp1(tbl[i].a, tbl[i].b, ec, tbl[i].useCf);
      check("tbl_f", rspF1, tbl[i].expF);
      check("tbl_cf", rspCf1, tbl[i].expCf);
      check("tbl_zf", rspZf1, tbl[i].expZf);
      release1();
    end

    // Backpressure for 5 cycles, then a same-edge response and accept
    accept1(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 4'h6, ec);
    waitRsp1(8'hFF, 8'h01, ec, 1'b0);
    reqA = 8'h10; reqB = 8'h10; reqCin = 1'b0; reqUseCf = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", rspValid1, 1);
      check("bp_rsp", {rspF1, rspCf1}, {mF, mCf});
      check("bp_req_ready", r1, 0);
    end
    rspReady1 = 1'b1;
    accept1(8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4'h9, ec);
    rspReady1 = 1'b0;
    check("b2b_rsp_valid", rspValid1, 0);
    waitRsp1(8'h10, 8'h10, ec, 1'b0);
    check("b2b_f", rspF1, 8'h20);
    release1();

    // Zero-flag chaining sequences
    runOp1(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h9);
    runOp1(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 4'h9);
    runOp1(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h9);
    runOp1(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4'h9);
    runOp1(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 4'h9);
    runOp1(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4'h9);

    // Randomized ops with random response delay
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); ru = 1'($urandom);
      accept1(ra, rb, rc, ru, 1'($urandom), 4'($urandom), ec);
      waitRsp1(ra, rb, ec, ru);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        check("rand_hold", {rspValid1, rspF1}, {1'b1, mF});
      end
      release1();
    end

    // Latency of dut3 with the ALU inputs held through the settle window
    reqA = 8'h3C; reqB = 8'h05; reqCin = 1'b0; reqUseCf = 1'b0; reqMode = 1'b1; reqSel = 4'hA;
    check("d3_ready", r3, 1);
    v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    reqA = 8'hEE; reqB = 8'hEE;
    for (int k = 1; k <= 3; k++) begin
      check("d3_valid", rspValid3, 0);
      check("d3_hold", {aluMode3, aluSel3, aluA3, aluB3, aluCin3}, {1'b1, 4'hA, 8'h3C, 8'h05, 1'b0});
      @(posedge clk); #1;
    end
    check("d3_valid_at_e3", rspValid3, 1);
    check("d3_rsp", {rspF3, rspCf3, rspZf3, cf3, zf3}, {8'h41, 4'b0000});
    rspReady3 = 1'b1;
    @(posedge clk); #1;
    rspReady3 = 1'b0;
    check("d3_idle", busy3, 0);

    // Reset mid-DRIVE on both instances after cf has been set on dut1
    runOp1(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 4'h9);
    reqA = 8'h77; reqB = 8'h88; reqCin = 1'b1;
    v1 = 1'b1; v3 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    check("pre_reset_busy", {busy1, busy3}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset_cf", cf1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mCf = 1'b0; mZf = 1'b0;
    check("rst_rsp_valid", {rspValid1, rspValid3}, 0);
    check("rst_flags", {cf1, zf1, cf3, zf3}, 0);
    check("rst_alu", {aluA1, aluB1, aluCin1, aluA3, aluCin3}, 0);
    check("rst_req_ready", {r1, r3}, 2'b11);
    check("rst_busy", {busy1, busy3}, 0);
    runOp1(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 4'h9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
